alu_result_capture: RTL and testbench
=====================================

// Module: alu_result_capture
// PURPOSE
//  Reader side of the sync_arith_unit ALU interface: tracks each issued operation
//  through the ALU's registered latency and captures the matching o_result/o_status.
//  Captured entries are buffered and presented as a valid/ready stream, with an issue
//  credit, a sticky overflow flag and an error counter. Sits directly behind the ALU,
//  between the ALU and any consumer/checker.
// PARAMETERS
//  N        2        opcode width (matches ALU N)
//  M        4        operand/result width (matches ALU M)
//  LAT      1        ALU clock latency from operand sample to result valid, 1..4
//  DEPTH    4        capture FIFO depth, power of 2, >= 2
//  ERR_MASK 4'b1011  status bits counted as error (bit 2 = zero flag, excluded)
// PORTS
//  i_clk          in   1      clock, rising edge
//  i_reset        in   1      synchronous reset, active-high
//  i_issue_valid  in   1      operation presented to ALU this cycle
//  i_issue_op     in   N      opcode presented to ALU this cycle
//  o_issue_ready  out  1      credit: issuing this cycle cannot overflow the FIFO
//  i_alu_result   in   M      ALU o_result
//  i_alu_status   in   4      ALU o_status
//  o_valid        out  1      capture entry available
//  i_ready        in   1      consumer accepts entry
//  o_op           out  N      opcode of head entry
//  o_result       out  M      result of head entry
//  o_status       out  4      status of head entry
//  o_error        out  1      |(o_status & ERR_MASK), qualified by o_valid
//  o_overflow     out  1      sticky: capture dropped because FIFO full
//  o_err_count    out  8      saturating count of captured entries with error
// BEHAVIOUR
//  - Reset (i_reset=1 at edge): tag pipeline, FIFO, overflow and counter cleared; o_valid=0,
//    o_op/o_result/o_status=0, o_error=0, o_overflow=0, o_err_count=0, o_issue_ready=1.
//    Reset mid-operation discards all in-flight tags and buffered entries; no partial output.
//  - Tag pipeline: LAT-stage shift register of {valid, op}. Stage 0 loads
//    {i_issue_valid, i_issue_op} every edge; a tag leaving stage LAT-1 is "arriving".
//  - Capture: on the edge following a tag's arrival cycle, FIFO pushes {op, i_alu_result,
//    i_alu_status} sampled in the arrival cycle. Total issue->o_valid latency = LAT+1 cycles
//    when FIFO empty.
//  - Pop: i_ready & o_valid at edge. Push and pop on the same edge both succeed, including
//    when full (count unchanged) and when empty-with-arrival (no pop since o_valid=0).
//  - Full push without pop: entry dropped, o_overflow set, stays set until reset.
//  - Credit: o_issue_ready = (count + inflight_tags) < DEPTH, combinational on registered
//    state; count treats an in-progress pop as not yet done. Issuing only when ready
//    guarantees no overflow; issuing regardless is legal.
//  - o_err_count increments on each successful push whose status&ERR_MASK != 0;
//    holds at 8'hFF.
//  - Head outputs are FIFO read data, stable while o_valid & !i_ready; 0 when empty.
//  - Pointers wrap modulo DEPTH; count width $clog2(DEPTH)+1.
//  - Arithmetic: all compares unsigned; result/status stored verbatim, no reinterpretation.
// STRUCTURE
//  - Package alu_capture_pkg: typedef struct capture_entry_t {op, result, status};
//    localparams STATUS_W=4, ERR_MASK_DEFAULT, ERR_CNT_W=8.
//  - Sub-module alu_capture_fifo: synchronous FIFO of capture_entry_t, push/pop/full/empty/
//    count, same clock/reset.
//  - Top: tag shift register, credit logic, error counter, overflow flag.
// TESTING
//  1 Reset then idle: o_valid=0, o_issue_ready=1, o_err_count=0 for 10 cycles.
//  2 LAT=1, issue op=00 A=3 B=1 once, i_ready=1: o_valid high exactly 2 cycles after issue,
//    o_op=00, o_result=4'b0001, single beat.
//  3 Issue 6 back-to-back ops with i_ready=0, DEPTH=4: o_issue_ready falls after 4th issue;
//    entries 5,6 dropped, o_overflow=1, FIFO holds first 4 in order.
//  4 Full FIFO, i_ready=1 with continuous arrivals: one push+pop per edge, count stays 4,
//    no overflow, order preserved.
//  5 Status 4'b0100 then 4'b1000 captured: first o_error=0, second o_error=1;
//    o_err_count=1. 300 error captures -> o_err_count=8'hFF.
//  6 Assert i_reset with 2 tags in flight and 3 entries buffered: next cycle o_valid=0,
//    o_overflow=0, no late capture appears LAT+1 cycles later.

Source files
------------

// File: rtl/alu_capture_pkg.sv
// rtl/alu_capture_pkg.sv - shared types and constants for the ALU result capture block
package alu_capture_pkg;

  localparam int OP_W     = 2;
  localparam int RES_W    = 4;
  localparam int STATUS_W = 4;
  localparam int ERR_CNT_W = 8;
  localparam logic [STATUS_W-1:0] ERR_MASK_DEFAULT = 4'b1011;

  typedef struct packed {
    logic [OP_W-1:0]     op;
    logic [RES_W-1:0]    result;
    logic [STATUS_W-1:0] status;
  } capture_entry_t;

  function automatic logic is_error(input logic [STATUS_W-1:0] status,
                                    input logic [STATUS_W-1:0] mask);
    return |(status & mask);
  endfunction

endpackage

// File: rtl/alu_capture_fifo.sv
// rtl/alu_capture_fifo.sv - synchronous FIFO of capture entries
// Push while full succeeds only when a pop happens on the same edge.
module alu_capture_fifo
  import alu_capture_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       i_clk,
  input  logic                       i_reset,
  input  logic                       i_push,
  input  capture_entry_t             i_data,
  input  logic                       i_pop,
  output capture_entry_t             o_data,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH):0]     o_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  capture_entry_t   mem_q [DEPTH];
  capture_entry_t   mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             pop_ok;
  logic             push_ok;

  assign o_full  = (count_q == CNT_W'(DEPTH));
  assign o_empty = (count_q == '0);
  assign o_count = count_q;
  assign o_data  = o_empty ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    pop_ok   = i_pop & ~o_empty;
    push_ok  = i_push & (~o_full | pop_ok);
    if (push_ok) begin
      mem_d[wr_ptr_q] = i_data;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    count_d = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
  end

  always_ff @(posedge i_clk) begin
    mem_q <= mem_d;
    if (i_reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/alu_result_capture.sv
// rtl/alu_result_capture.sv - tracks issued ALU ops through the ALU latency and buffers results
// Tag pipeline, issue credit, sticky overflow and saturating error counter around the FIFO.
module alu_result_capture
  import alu_capture_pkg::*;
#(
  parameter int                  N        = OP_W,
  parameter int                  M        = RES_W,
  parameter int                  LAT      = 1,
  parameter int                  DEPTH    = 4,
  parameter logic [STATUS_W-1:0] ERR_MASK = ERR_MASK_DEFAULT
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_issue_valid,
  input  logic [N-1:0]         i_issue_op,
  output logic                 o_issue_ready,
  input  logic [M-1:0]         i_alu_result,
  input  logic [3:0]           i_alu_status,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic [N-1:0]         o_op,
  output logic [M-1:0]         o_result,
  output logic [3:0]           o_status,
  output logic                 o_error,
  output logic                 o_overflow,
  output logic [7:0]           o_err_count
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int INF_W = 3;
  localparam int SUM_W = CNT_W + INF_W;

  logic [LAT-1:0]       tag_valid_q, tag_valid_d;
  logic [N-1:0]         tag_op_q [LAT];
  logic [N-1:0]         tag_op_d [LAT];
  logic                 overflow_q, overflow_d;
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

  logic                 arriving;
  logic                 pop;
  logic                 push_accept;
  logic [INF_W-1:0]     inflight;
  logic [SUM_W-1:0]     credit_sum;
  capture_entry_t       cap_entry;
  capture_entry_t       head;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [CNT_W-1:0]     fifo_count;

  alu_capture_fifo #(.DEPTH(DEPTH)) u_fifo (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_push  (arriving),
    .i_data  (cap_entry),
    .i_pop   (pop),
    .o_data  (head),
    .o_full  (fifo_full),
    .o_empty (fifo_empty),
    .o_count (fifo_count)
  );

  assign o_valid     = ~fifo_empty;
  assign o_op        = head.op;
  assign o_result    = head.result;
  assign o_status    = head.status;
  assign o_error     = o_valid & is_error(head.status, ERR_MASK);
  assign o_overflow  = overflow_q;
  assign o_err_count = err_cnt_q;

  // The ALU result seen while a tag leaves the last stage belongs to that tag.
  always_comb begin
    arriving         = tag_valid_q[LAT-1];
    cap_entry.op     = tag_op_q[LAT-1];
    cap_entry.result = i_alu_result;
    cap_entry.status = i_alu_status;
    pop              = o_valid & i_ready;
    push_accept      = arriving & (~fifo_full | pop);
  end

  always_comb begin
    tag_valid_d    = tag_valid_q;
    tag_op_d       = tag_op_q;
    tag_valid_d[0] = i_issue_valid;
    tag_op_d[0]    = i_issue_op;
    for (int i = 1; i < LAT; i++) begin
      tag_valid_d[i] = tag_valid_q[i-1];
      tag_op_d[i]    = tag_op_q[i-1];
    end
  end

  // Credit counts every tag still in flight as an entry already owning a slot.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < LAT; i++) begin
      inflight = inflight + INF_W'(tag_valid_q[i]);
    end
    credit_sum    = SUM_W'(fifo_count) + SUM_W'(inflight);
    o_issue_ready = (credit_sum < SUM_W'(DEPTH));
  end

  always_comb begin
    overflow_d = overflow_q | (arriving & fifo_full & ~pop);
    err_cnt_d  = err_cnt_q;
    if (push_accept && is_error(i_alu_status, ERR_MASK) && (err_cnt_q != '1)) begin
      err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      tag_valid_q <= '0;
      for (int i = 0; i < LAT; i++) begin
        tag_op_q[i] <= '0;
      end
      overflow_q <= 1'b0;
      err_cnt_q  <= '0;
    end else begin
      tag_valid_q <= tag_valid_d;
      tag_op_q    <= tag_op_d;
      overflow_q  <= overflow_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

endmodule

// File: tb/tb_alu_result_capture.sv
// tb/tb_alu_result_capture.sv - scoreboard bench for alu_result_capture (LAT=1, DEPTH=4)
module tb_alu_result_capture;

  logic       clk;
  logic       i_reset;
  logic       i_issue_valid;
  logic [1:0] i_issue_op;
  logic       o_issue_ready;
  logic [3:0] i_alu_result;
  logic [3:0] i_alu_status;
  logic       o_valid;
  logic       i_ready;
  logic [1:0] o_op;
  logic [3:0] o_result;
  logic [3:0] o_status;
  logic       o_error;
  logic       o_overflow;
  logic [7:0] o_err_count;

  int n_cmp = 0;
  int n_bad = 0;

  // {op, result, status, error}
  logic [10:0] exp_q [$];
  logic [3:0]  alu_res_n = '0;
  logic [3:0]  alu_st_n  = '0;

  alu_result_capture dut (
    .i_clk         (clk),
    .i_reset       (i_reset),
    .i_issue_valid (i_issue_valid),
    .i_issue_op    (i_issue_op),
    .o_issue_ready (o_issue_ready),
    .i_alu_result  (i_alu_result),
    .i_alu_status  (i_alu_status),
    .o_valid       (o_valid),
    .i_ready       (i_ready),
    .o_op          (o_op),
    .o_result      (o_result),
    .o_status      (o_status),
    .o_error       (o_error),
    .o_overflow    (o_overflow),
    .o_err_count   (o_err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: drive this cycle's issue, and the ALU output for last cycle's issue (LAT=1).
  task automatic cyc(input logic iv, input logic [1:0] op, input logic [3:0] res,
                     input logic [3:0] st, input logic err, input logic keep);
    i_issue_valid = iv;
    i_issue_op    = op;
    i_alu_result  = alu_res_n;
    i_alu_status  = alu_st_n;
    if (iv && keep) exp_q.push_back({op, res, st, err});
    alu_res_n = res;
    alu_st_n  = st;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    i_reset       = 1'b1;
    i_issue_valid = 1'b0;
    @(posedge clk);
    #1;
    i_reset = 1'b0;
    exp_q.delete();
  endtask

  task automatic drain();
    int k;
    k = 0;
    i_ready = 1'b1;
    while (exp_q.size() != 0 && k < 50) begin
      cyc(1'b0, 2'd0, 4'd0, 4'd0, 1'b0, 1'b0);
      k++;
    end
    chk("drain_left", exp_q.size(), 0);
  endtask

  // Monitor: every accepted beat must match the oldest expected entry.
  always @(negedge clk) begin
    logic [10:0] e;
    if (!i_reset && o_valid && i_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_beat", {o_op, o_result, o_status}, 0);
        if ({o_op, o_result, o_status} == 0) begin
          n_bad++;
          $display("FAIL unexpected_beat: got op=%0h res=%0h st=%0h expected none", o_op, o_result, o_status);
        end
      end else begin
        e = exp_q.pop_front();
        chk("head_op", o_op, e[10:9]);
        chk("head_result", o_result, e[8:5]);
        chk("head_status", o_status, e[4:1]);
        chk("head_error", o_error, e[0]);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [3:0] res_tab [6];
    res_tab = '{4'h1, 4'h7, 4'hA, 4'hF, 4'h3, 4'h5};
    i_reset = 1'b1; i_issue_valid = 0; i_issue_op = 0;
    i_alu_result = 0; i_alu_status = 0; i_ready = 0;

    // 1: reset then idle
    do_reset();
    chk("rst_op", o_op, 0);
    chk("rst_result", o_result, 0);
    chk("rst_status", o_status, 0);
    chk("rst_error", o_error, 0);
    chk("rst_overflow", o_overflow, 0);
    for (int k = 0; k < 10; k++) begin
      cyc(1'b0, 2'd0, 4'd0, 4'd0, 1'b0, 1'b0);
      chk("idle_valid", o_valid, 0);
      chk("idle_ready", o_issue_ready, 1);
      chk("idle_errcnt", o_err_count, 0);
    end

    // 2: single op, latency LAT+1
    do_reset();
    i_ready = 1'b1;
    cyc(1'b1, 2'b00, 4'b0001, 4'b0000, 1'b0, 1'b1);
    chk("lat_valid_c1", o_valid, 0);
    cyc(1'b0, 2'd0, 4'd0, 4'd0, 1'b0, 1'b0);
    chk("lat_valid_c2", o_valid, 1);
    chk("lat_op", o_op, 2'b00);
    chk("lat_result", o_result, 4'b0001);
    cyc(1'b0, 2'd0, 4'd0, 4'd0, 1'b0, 1'b0);
    chk("lat_single_beat", o_valid, 0);

    // 3: overflow with consumer stalled
    do_reset();
    i_ready = 1'b0;
    for (int k = 0; k < 6; k++) begin
      chk("credit", o_issue_ready, (k < 4) ? 1 : 0);
      cyc(1'b1, k[1:0], res_tab[k], 4'b0000, 1'b0, (k < 4));
    end
    cyc(1'b0, 2'd0, 4'd0, 4'd0, 1'b0, 1'b0);
    chk("ovf_flag", o_overflow, 1);
    chk("ovf_head_op", o_op, 2'd0);
    chk("ovf_head_res", o_result, 4'h1);
    drain();
    chk("ovf_dropped", o_valid, 0);
    chk("ovf_sticky", o_overflow, 1);

    // 4: full FIFO streaming, push and pop each edge
    do_reset();
    i_ready = 1'b0;
    for (int k = 0; k < 5; k++) cyc(1'b1, k[1:0], k[3:0], 4'b0100, 1'b0, 1'b1);
    i_ready = 1'b1;
    for (int k = 5; k < 12; k++) begin
      cyc(1'b1, k[1:0], k[3:0], (k[0] ? 4'b0100 : 4'b0000), 1'b0, 1'b1);
      chk("stream_valid", o_valid, 1);
      chk("stream_credit", o_issue_ready, 0);
      chk("stream_no_ovf", o_overflow, 0);
    end
    drain();
    chk("stream_no_ovf_end", o_overflow, 0);

    // 5: error flag and counter saturation
    do_reset();
    i_ready = 1'b0;
    cyc(1'b1, 2'd1, 4'h0, 4'b0100, 1'b0, 1'b1);
    cyc(1'b1, 2'd2, 4'h9, 4'b1000, 1'b1, 1'b1);
    cyc(1'b0, 2'd0, 4'd0, 4'd0, 1'b0, 1'b0);
    chk("err_first", o_error, 0);
    chk("err_count_1", o_err_count, 1);
    i_ready = 1'b1;
    cyc(1'b0, 2'd0, 4'd0, 4'd0, 1'b0, 1'b0);
    chk("err_second", o_error, 1);
    drain();
    for (int k = 0; k < 300; k++) begin
      cyc(1'b1, k[1:0], k[3:0], 4'b0001, 1'b1, 1'b1);
      if (k == 100) chk("err_count_101", o_err_count, 101);
    end
    drain();
    chk("err_count_sat", o_err_count, 8'hFF);

    // 6: reset with work in flight and buffered
    do_reset();
    i_ready = 1'b0;
    for (int k = 0; k < 4; k++) cyc(1'b1, k[1:0], 4'hC, 4'b0010, 1'b1, 1'b1);
    i_reset = 1'b1;
    cyc(1'b1, 2'd3, 4'hE, 4'b0001, 1'b1, 1'b0);
    i_reset = 1'b0;
    exp_q.delete();
    chk("rst6_valid", o_valid, 0);
    chk("rst6_overflow", o_overflow, 0);
    chk("rst6_ready", o_issue_ready, 1);
    chk("rst6_errcnt", o_err_count, 0);
    i_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      cyc(1'b0, 2'd0, 4'd0, 4'd0, 1'b0, 1'b0);
      chk("rst6_no_late", o_valid, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
